em_skid_buffer: RTL
===================

Name: em_skid_buffer

Overview:
Parametrised EX/MEM pipeline buffer. Replaces the fixed-width, always-advancing stage register with a valid/ready handshake, a 2-entry skid for stall absorption, synchronous flush, and bubble-safe control gating. Sits between the execute and memory-access stages.

Parameters:
DATA_W, 32, width of alu_result and rt_data
ADDR_W, 32, width of branch_addr
REG_ADDR_W, 5, width of write_addr_reg
STAT_W, 16, width of the optional statistics counters

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
flush_i  in  1  synchronous kill of all held entries
in_valid_i  in  1  execute stage presents an entry
in_ready_o  out  1  buffer can accept; equals (state != TWO)
ctrl_i  in  6  {zf, reg_write, mem_write, mem_to_reg, mem_read, branch}, bit5..bit0
branch_addr_i  in  ADDR_W  branch target
alu_result_i  in  DATA_W  ALU result
rt_data_i  in  DATA_W  store data
write_addr_reg_i  in  REG_ADDR_W  destination register
out_valid_o  out  1  memory stage entry valid
out_ready_i  in  1  memory stage consumes the entry
ctrl_o  out  6  head-entry control bits, same map, masked by out_valid_o
branch_addr_o  out  ADDR_W  head entry
alu_result_o  out  DATA_W  head entry
rt_data_o  out  DATA_W  head entry
write_addr_reg_o  out  REG_ADDR_W  head entry
taken_o  out  1  out_valid_o & ctrl_o[0] & ctrl_o[5]
stall_cnt_o  out  STAT_W  optional, see below
flush_cnt_o  out  STAT_W  optional, see below

Behaviour:
- Storage: head register (drives outputs) and skid register. State: EMPTY, ONE (head only), TWO (head and skid).
- Accept = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
- EMPTY: accept -> head<=in, go to ONE.
- ONE: accept & pop -> head<=in, stay ONE. Accept & !pop -> skid<=in, go to TWO. !accept & pop -> EMPTY. Neither -> hold.
- TWO: in_ready_o=0, so in_valid_i is ignored. Pop -> head<=skid, go to ONE. Otherwise hold.
- Ordering: entries leave in acceptance order. Latency is 1 cycle from accept to out_valid_o when EMPTY. Full throughput of 1/cycle when out_ready_i stays high.
- Output registers: no combinational path from in_* to out_* data or ctrl. in_ready_o depends on state only, never on out_ready_i.
- Priority: rst_i > flush_i > normal operation.
- Reset: state EMPTY. Head and skid data/ctrl cleared to 0. All outputs read 0; in_ready_o=1 after the reset edge. Inputs presented during a reset cycle are discarded. Reset mid-stall drops both entries.
- Flush: state goes to EMPTY next edge. An entry offered in the flush cycle is dropped even if in_ready_o=1. A pop coinciding with flush still counts as consumed by the memory stage. Data registers may keep stale values.
- Bubble safety: ctrl_o = stored ctrl & {6{out_valid_o}}, so no reg_write, mem_write, mem_read or branch side effects from an empty slot. Data outputs are unmasked.
- Hold: while out_valid_o & !out_ready_i, all out_* stay stable.

Optional Feature:
Macro EM_SKID_BUFFER_STATS_EN.
- Defined: stall_cnt_o increments each cycle with out_valid_o & !out_ready_i. flush_cnt_o increments each cycle flush_i=1 while state != EMPTY. Both saturate at all-ones and clear on rst_i.
- Undefined: both ports tie to 0 and no counter logic is generated.

Test Plan:
- Reset, then stream alu_result 1,2,3 with out_ready_i=1 -> out_valid_o from cycle+1, outputs 1,2,3 on consecutive cycles, in_ready_o always 1.
- Accept 0xA, 0xB with out_ready_i=0 -> state TWO, in_ready_o=0, offered 0xC ignored. Release out_ready_i -> 0xA then 0xB; 0xC accepted once in_ready_o returns to 1.
- Hold two entries, assert flush_i with in_valid_i=1 and data 0xD -> next cycle out_valid_o=0, ctrl_o=0, 0xD never appears.
- Entry with branch=1, zf=1, branch_addr=0x40 -> taken_o=1 for exactly its valid cycle. With zf=0 -> taken_o=0. When empty, taken_o=0.
- rst_i asserted while state TWO with reg_write=1 -> next cycle all outputs 0, in_ready_o=1, and stats counters=0 if enabled.
- With STATS_EN and STAT_W=2, hold out_ready_i=0 for 5 cycles with a valid entry -> stall_cnt_o reads 1,2,3,3,3.

Source files
------------

// File: rtl/em_skid_buffer.sv
// EX/MEM pipeline buffer: valid/ready handshake, 2-entry skid, synchronous flush.
// Optional stall/flush statistics counters: define EM_SKID_BUFFER_STATS_EN.
module em_skid_buffer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int STAT_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [5:0]            ctrl_i,
    input  logic [ADDR_W-1:0]     branch_addr_i,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic [DATA_W-1:0]     rt_data_i,
    input  logic [REG_ADDR_W-1:0] write_addr_reg_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [5:0]            ctrl_o,
    output logic [ADDR_W-1:0]     branch_addr_o,
    output logic [DATA_W-1:0]     alu_result_o,
    output logic [DATA_W-1:0]     rt_data_o,
    output logic [REG_ADDR_W-1:0] write_addr_reg_o,
    output logic                  taken_o,
    output logic [STAT_W-1:0]     stall_cnt_o,
    output logic [STAT_W-1:0]     flush_cnt_o
);
    localparam int ENTRY_W = 6 + ADDR_W + 2 * DATA_W + REG_ADDR_W;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state, nextState;
    logic [ENTRY_W-1:0] headEntry, skidEntry, inEntry;
    logic [5:0]         headCtrl;
    logic               accept, pop, outValid;
    logic               loadHeadIn, loadHeadSkid, loadSkid;

    assign inEntry    = {ctrl_i, branch_addr_i, alu_result_i, rt_data_i, write_addr_reg_i};
    assign outValid   = (state != EMPTY);
    assign in_ready_o = (state != TWO);
    assign accept     = in_valid_i & in_ready_o;
    assign pop        = outValid & out_ready_i;

    always_comb begin
        nextState    = state;
        loadHeadIn   = 1'b0;
        loadHeadSkid = 1'b0;
        loadSkid     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    loadHeadIn = 1'b1;
                    nextState  = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    loadHeadIn = 1'b1;
                end else if (accept) begin
                    loadSkid  = 1'b1;
                    nextState = TWO;
                end else if (pop) begin
                    nextState = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    loadHeadSkid = 1'b1;
                    nextState    = ONE;
                end
            end
            default: nextState = EMPTY;
        endcase
        // Flush drops everything, including an entry offered this same cycle.
        if (flush_i) begin
            nextState    = EMPTY;
            loadHeadIn   = 1'b0;
            loadHeadSkid = 1'b0;
            loadSkid     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= EMPTY;
            headEntry <= '0;
            skidEntry <= '0;
        end else begin
            state <= nextState;
            if (loadHeadIn)
                headEntry <= inEntry;
            else if (loadHeadSkid)
                headEntry <= skidEntry;
            if (loadSkid)
                skidEntry <= inEntry;
        end
    end

    assign {headCtrl, branch_addr_o, alu_result_o, rt_data_o, write_addr_reg_o} = headEntry;
    assign out_valid_o = outValid;
    assign ctrl_o      = headCtrl & {6{outValid}};
    assign taken_o     = outValid & headCtrl[0] & headCtrl[5];

`ifdef EM_SKID_BUFFER_STATS_EN
    logic [STAT_W-1:0] stallCnt, flushCnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (outValid && !out_ready_i && (stallCnt != '1))
                stallCnt <= stallCnt + 1'b1;
            if (flush_i && (state != EMPTY) && (flushCnt != '1))
                flushCnt <= flushCnt + 1'b1;
        end
    end

    assign stall_cnt_o = stallCnt;
    assign flush_cnt_o = flushCnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
